// File: rtl/edsac_pkg.sv
// Shared definitions for the EDSAC-style mercury tank port: geometry defaults,
// address width and the port state machine encoding.
package edsac_pkg;

  localparam int WORDS_DEF  = 16;
  localparam int DIGITS_DEF = 36;
  localparam int ADDR_W_DEF = $clog2(WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } port_state_e;

  // Word slot that immediately precedes w on the circulating tank.
  function automatic int prev_word(input int w, input int words);
    return (w == 0) ? words - 1 : w - 1;
  endfunction

endpackage

// File: rtl/tank_timer.sv
// Free-running tank phase counter: digit d every cycle, word w every DIGITS
// cycles, with a strobe on the last digit of each word slot.
module tank_timer
  import edsac_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int AW     = $clog2(WORDS),
  parameter int DW     = $clog2(DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] w,
  output logic [DW-1:0] d,
  output logic          slot_end
);

  localparam logic [AW-1:0] W_LAST = AW'(WORDS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

  assign slot_end = (d == D_LAST);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w <= '0;
      d <= '0;
    end else if (slot_end) begin
      d <= '0;
      w <= (w == W_LAST) ? '0 : w + 1'b1;
    end else begin
      d <= d + 1'b1;
    end
  end

endmodule

// File: rtl/tank_port.sv
// Word-level request port onto a serial recirculating tank: waits for the
// addressed slot to come round, then shifts one word in or out LSB first.
module tank_port
  import edsac_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [$clog2(WORDS)-1:0] req_addr,
  input  logic [DIGITS-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DIGITS-1:0]        rsp_rdata,
  output logic                     mib,
  output logic                     tn_in,
  output logic                     tn_clr,
  output logic                     tn_out,
  input  logic                     mob_tn
);

  localparam int AW = $clog2(WORDS);
  localparam int DW = $clog2(DIGITS);

  logic [AW-1:0]     w;
  logic [DW-1:0]     d;
  logic              slot_end;

  port_state_e       state, state_nxt;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [DIGITS-1:0] wdata_q;
  logic [DIGITS-1:0] cap_q, cap_nxt;
  logic [DIGITS-1:0] rdata_q;

  logic              handshake;
  logic              slot_hit;
  logic              in_xfer;

  tank_timer #(
    .WORDS  (WORDS),
    .DIGITS (DIGITS),
    .AW     (AW),
    .DW     (DW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .w        (w),
    .d        (d),
    .slot_end (slot_end)
  );

  assign handshake = req_valid && req_ready;
  // Last digit of the slot before ours: the next edge lands on (addr_q, 0).
  assign slot_hit  = slot_end && (w == AW'(prev_word(int'(addr_q), WORDS)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (handshake) state_nxt = WAIT;
      WAIT:    if (slot_hit)  state_nxt = XFER;
      XFER:    if (slot_end)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gates decode straight from the state register, so an asynchronous reset
  // drops them in the same cycle without waiting for a clock edge.
  assign in_xfer   = (state == XFER);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign tn_in     = in_xfer && wr_q;
  assign tn_out    = in_xfer && !wr_q;
  assign tn_clr    = !tn_in;
  assign mib       = tn_in && wdata_q[d];
  assign rsp_rdata = rdata_q;

  always_comb begin
    cap_nxt    = cap_q;
    cap_nxt[d] = mob_tn;
  end

  // NOTE: the datapath flops are reset as well as the FSM, because rsp_rdata
  // must read zero out of reset and abandoned captures must not leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (handshake) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (tn_out) begin
        cap_q <= cap_nxt;
        if (slot_end) rdata_q <= cap_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tank_port.sv
// Self-checking bench for tank_port: a serial tank model, directed vectors for
// slot timing / wrap / missed-slot latency, a mid-transfer reset, random traffic.
module tb_tank_port;
  import edsac_pkg::*;

  localparam int W = 16;
  localparam int D = 36;
  localparam int N = W * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [35:0] req_wdata = '0;
  logic        mob_tn = 1'b0;
  logic        req_ready, rsp_valid, mib, tn_in, tn_clr, tn_out;
  logic [35:0] rsp_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          t;
  logic [35:0] tank    [W];
  logic [35:0] ref_mem [W];
  logic [35:0] exp_rd;

  typedef struct {
    logic        wr;
    int          addr;
    logic [35:0] wdata;
    int          hs_pos;
    logic [35:0] exp_rdata;
    int          exp_lat;
    int          exp_gap;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  tank_port #(.WORDS(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mib       (mib),
    .tn_in     (tn_in),
    .tn_clr    (tn_clr),
    .tn_out    (tn_out),
    .mob_tn    (mob_tn)
  );

  // Tank phase: number of rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  // Recirculating tank: stores mib while written, presents the current bit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tn_in && !tn_clr) tank[(t % N) / D][(t % N) % D] = mib;
      mob_tn = tank[(t % N) / D][(t % N) % D];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int first_xfer(input int p, input int addr);
    int s;
    s = addr * D;
    return p + 1 + (((s - p - 2) % N + N) % N) + 1;
  endfunction

  // Issues one request (called at a negedge) and compares every cycle's gates,
  // mib, rsp_valid and req_ready against the slot schedule until it is idle.
  task automatic run_req(input string tag, input logic wr, input int addr,
                         input logic [35:0] wd, input int hs_pos,
                         output int lat, output int gap);
    int p, start, done_t, errs;
    logic e_in, e_out, e_mib;
    if (hs_pos >= 0) begin
      for (int k = 0; k < N && (t % N) != hs_pos; k++) @(negedge clk);
    end
    check({tag, " ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = 4'(addr);
    req_wdata = wd;
    p      = t;
    start  = first_xfer(p, addr);
    done_t = start + D;
    errs   = 0;
    lat    = -1;
    gap    = -1;
    @(negedge clk);
    req_valid = 1'b0;
    while (t <= done_t + 1) begin
      e_in  = (t >= start) && (t < start + D) && wr;
      e_out = (t >= start) && (t < start + D) && !wr;
      e_mib = e_in ? wd[t - start] : 1'b0;
      if (tn_in !== e_in || tn_out !== e_out || tn_clr !== !e_in || mib !== e_mib ||
          rsp_valid !== (t == done_t) || req_ready !== (t > done_t)) errs++;
      if ((tn_in || tn_out) && gap < 0) gap = t - p;
      if (rsp_valid && lat < 0) lat = t - p;
      @(negedge clk);
      req_wdata = 36'({$urandom(), $urandom()});
      req_write = 1'($urandom());
      req_addr  = 4'($urandom());
    end
    check({tag, " cycle errors"}, errs, 0);
  endtask

  initial begin
    int lat, gap, p, start, hits;
    logic        r_wr;
    int          r_addr, r_hs;
    logic [35:0] r_wd;

    for (int i = 0; i < W; i++) begin
      tank[i]    = 36'h0F0F0F0F0 ^ 36'(i);
      ref_mem[i] = 36'h0F0F0F0F0 ^ 36'(i);
    end

    vecs[0] = '{1'b1, 3,  36'h800000005, -1,  36'h000000000, 0,   0};
    vecs[1] = '{1'b0, 3,  36'h0,         -1,  36'h800000005, 0,   0};
    vecs[2] = '{1'b1, 15, 36'h123456789, -1,  36'h800000005, 0,   0};
    vecs[3] = '{1'b0, 0,  36'h0,         574, 36'h0F0F0F0F0, 0,   2};
    vecs[4] = '{1'b0, 15, 36'h0,         -1,  36'h123456789, 0,   0};
    vecs[5] = '{1'b1, 7,  36'hFFFFFFFFF, 251, 36'h123456789, 613, 577};
    vecs[6] = '{1'b0, 7,  36'h0,         250, 36'hFFFFFFFFF, 38,  2};
    vecs[7] = '{1'b1, 0,  36'h5A5A5A5A5, 575, 36'hFFFFFFFFF, 613, 577};
    vecs[8] = '{1'b0, 0,  36'h0,         -1,  36'h5A5A5A5A5, 0,   0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset ready", req_ready, 1'b1);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rdata", rsp_rdata, 36'h0);
    check("reset gates", {mib, tn_in, tn_out, tn_clr}, 4'b0001);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].hs_pos, lat, gap);
      check($sformatf("vec%0d rdata", i), rsp_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_lat != 0) check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].exp_gap != 0) check($sformatf("vec%0d xfer start", i), gap, vecs[i].exp_gap);
      if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
    end
    exp_rd = 36'h5A5A5A5A5;

    // Reset asserted at digit 20 of a read transfer
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd5;
    p     = t;
    start = first_xfer(p, 5);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 2 * N && t < start + 20; k++) @(negedge clk);
    check("abort in xfer", tn_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort gates", {tn_in, tn_out, tn_clr, mib, rsp_valid, req_ready}, 6'b001001);
    check("abort rdata", rsp_rdata, 36'h0);
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      if (rsp_valid) hits++;
    end
    check("abort no rsp", hits, 0);
    exp_rd = 36'h0;
    run_req("after abort", 1'b0, 5, 36'h0, -1, lat, gap);
    check("after abort rdata", rsp_rdata, ref_mem[5]);
    exp_rd = ref_mem[5];

    // Random traffic against the word-level memory model
    for (int i = 0; i < 20; i++) begin
      r_wr   = 1'($urandom());
      r_addr = int'($urandom_range(W - 1));
      r_wd   = 36'({$urandom(), $urandom()});
      r_hs   = ($urandom_range(2) == 0) ? int'($urandom_range(N - 1)) : -1;
      run_req($sformatf("rnd%0d", i), r_wr, r_addr, r_wd, r_hs, lat, gap);
      if (r_wr) ref_mem[r_addr] = r_wd;
      else      exp_rd = ref_mem[r_addr];
      check($sformatf("rnd%0d rdata", i), rsp_rdata, exp_rd);
      check($sformatf("rnd%0d latency", i), lat, first_xfer(0, r_addr) + D - 0 -
            (first_xfer(0, r_addr) - gap));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tank_port.md
TANK_PORT -- requirements
Module: tank_port

Interface
REQ-001 Parameter WORDS, default 16: words per tank (minor cycles per major cycle).
REQ-002 Parameter DIGITS, default 36: bit slots per word.
REQ-003 clk  input  1  sole clock, rising edge; one tank bit time per cycle.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_write  input  1  1 = write word, 0 = read word.
REQ-008 req_addr  input  $clog2(WORDS)  target word slot.
REQ-009 req_wdata  input  DIGITS  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  DIGITS  read data; holds until the next read completes.
REQ-012 mib  output  1  serial data to tank input bus.
REQ-013 tn_in  output  1  tank write gate, active-high.
REQ-014 tn_clr  output  1  tank recirculation clear, active-low (idle 1).
REQ-015 tn_out  output  1  tank read gate, active-high.
REQ-016 mob_tn  input  1  serial data from tank output bus, valid in the same cycle as tn_out.

Function
REQ-017 Free-running position counter (word w 0..WORDS-1, digit d 0..DIGITS-1): d increments every cycle; d wraps 35->0 and increments w; w wraps WORDS-1->0; the counter defines tank phase.
REQ-018 FSM states IDLE, WAIT, XFER, DONE.
REQ-019 req_ready = 1 only in IDLE; a handshake (req_valid & req_ready) latches write, addr and wdata and enters WAIT.
REQ-020 WAIT->XFER at the edge where the counter moves from (addr-1 mod WORDS, DIGITS-1) to (addr, 0); XFER spans exactly the DIGITS cycles of slot addr.
REQ-021 Handshake at counter (addr-1, DIGITS-1) misses the slot and waits one full revolution; worst-case request-to-rsp_valid is WORDS*DIGITS+DIGITS+1 cycles.
REQ-022 Serial order LSB first: digit d carries bit d of the word.
REQ-023 Write XFER: tn_in=1, tn_clr=0, mib=wdata[d]; tn_out=0.
REQ-024 Read XFER: tn_out=1, tn_clr=1, tn_in=0, mib=0; mob_tn sampled into rdata[d] at each rising edge.
REQ-025 Outside XFER: tn_in=0, tn_out=0, tn_clr=1, mib=0.
REQ-026 XFER->DONE after digit DIGITS-1; DONE asserts rsp_valid for one cycle, then IDLE.
REQ-027 rsp_rdata updates only at a read completion; writes leave it unchanged.
REQ-028 Inputs ignored outside the handshake; req_wdata changes during WAIT/XFER have no effect.

Reset
REQ-029 While rst_n=0: state IDLE, counter (0,0), req_ready=1, rsp_valid=0, rsp_rdata=0, mib=0, tn_in=0, tn_out=0, tn_clr=1.
REQ-030 Reset asserted mid-XFER drops all gates within the same cycle (asynchronously); the partial transfer is abandoned and no rsp_valid is produced.
REQ-031 After rst_n release the counter starts at (0,0) on the first rising edge.

Structure
REQ-032 Shared package edsac_pkg holds WORDS, DIGITS defaults, the address width and the FSM state enum.
REQ-033 One sub-module, tank_timer, implements the position counter and exports w, d and the slot-boundary strobe.

Verification
REQ-034 Reset, then write addr 3 = 36'h8_0000_0005 -> tn_in/tn_clr low asserted exactly during counter (3,0..35); mib = 1,0,1,0...,1 at d=35; rsp_valid one cycle after (3,35).
REQ-035 Read addr 3 after REQ-034 with tank model -> rsp_rdata = 36'h8_0000_0005, tn_out high 36 cycles only.
REQ-036 Handshake at counter (6,35) for addr 7 -> XFER begins at (7,0) one revolution later; latency 577+36 cycles.
REQ-037 Handshake at (6,34) for addr 7 -> XFER starts at (7,0) two cycles later.
REQ-038 Write addr 15 then read addr 0 -> counter wrap 15->0 handled; each slot read back correctly.
REQ-039 rst_n low at XFER digit 20 -> all gates idle immediately, no rsp_valid, next request served normally.
